// File: rtl/proc_pkg.sv
// Shared encodings for the simple processor: opcodes, bus selects, ALU ops, sequencer states.
// State set grows by a HALT state when PROC_CTRL_ILLEGAL_TRAP_EN is defined.
package proc_pkg;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVT = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b110;

  localparam logic [3:0] SEL_IMM = 4'd8;
  localparam logic [3:0] SEL_G   = 4'd9;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;

  typedef enum logic [1:0] {
    CLS_MV,
    CLS_MVT,
    CLS_ALU,
    CLS_ILL
  } op_class_t;

`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
  typedef enum logic [2:0] {
    ST_T0,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_HALT
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_T0,
    ST_T1,
    ST_T2,
    ST_T3
  } state_t;
`endif

endpackage

// File: rtl/proc_ctrl_decode.sv
// Combinational instruction decode: splits the IR word into opcode class, register fields,
// immediate flag and ALU operation.
module proc_ctrl_decode
  import proc_pkg::*;
#(
  parameter int IR_W = 16
) (
  input  logic [IR_W-1:0] ir,
  output op_class_t       op_class,
  output logic [7:0]      rx_onehot,
  output logic [2:0]      rx,
  output logic [2:0]      ry,
  output logic            imm,
  output logic [1:0]      alu_op
);

  logic [2:0] opcode;
  logic       unused_ir;

  assign opcode    = ir[IR_W-1 -: 3];
  assign imm       = ir[IR_W-4];
  assign rx        = ir[IR_W-5 -: 3];
  assign ry        = ir[2:0];
  // Middle bits carry the MVT immediate, consumed by the bus mux, not here.
  assign unused_ir = ^ir[IR_W-8:3];

  always_comb begin
    op_class = CLS_ILL;
    alu_op   = ALU_ADD;
    case (opcode)
      OP_MV:  op_class = CLS_MV;
      OP_MVT: op_class = CLS_MVT;
      OP_ADD: begin
        op_class = CLS_ALU;
        alu_op   = ALU_ADD;
      end
      OP_SUB: begin
        op_class = CLS_ALU;
        alu_op   = ALU_SUB;
      end
      OP_AND: begin
        op_class = CLS_ALU;
        alu_op   = ALU_AND;
      end
      default: ;
    endcase
  end

  always_comb begin
    rx_onehot     = '0;
    rx_onehot[rx] = 1'b1;
  end

endmodule

// File: rtl/proc_ctrl_fsm.sv
// T0..T3 control sequencer for the 16-bit simple processor; outputs are combinational from state and ir.
// Optional illegal-opcode trap (HALT state, 'illegal' port) enabled by PROC_CTRL_ILLEGAL_TRAP_EN.
module proc_ctrl_fsm
  import proc_pkg::*;
#(
  parameter int IR_W  = 16,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [IR_W-1:0]  ir,
  output logic             ir_in,
  output logic [7:0]       r_in,
  output logic             a_in,
  output logic             g_in,
  output logic [1:0]       alu_op,
  output logic [SEL_W-1:0] sel,
  output logic             done
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
  ,
  output logic             illegal
`endif
);

  state_t    state;
  state_t    state_next;
  op_class_t op_class;
  logic [7:0] rx_onehot;
  logic [2:0] rx;
  logic [2:0] ry;
  logic       imm;
  logic [1:0] dec_alu_op;
  logic [SEL_W-1:0] operand_sel;

  proc_ctrl_decode #(
    .IR_W(IR_W)
  ) u_decode (
    .ir       (ir),
    .op_class (op_class),
    .rx_onehot(rx_onehot),
    .rx       (rx),
    .ry       (ry),
    .imm      (imm),
    .alu_op   (dec_alu_op)
  );

  assign operand_sel = imm ? SEL_W'(SEL_IMM) : SEL_W'(ry);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_T0;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    ir_in      = 1'b0;
    r_in       = '0;
    a_in       = 1'b0;
    g_in       = 1'b0;
    alu_op     = ALU_ADD;
    sel        = '0;
    done       = 1'b0;
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
    illegal    = 1'b0;
`endif
    // Reset masks every output so no pulse escapes from an abandoned instruction.
    if (!rst) begin
      case (state)
        ST_T0: begin
          ir_in = run;
          if (run) state_next = ST_T1;
        end
        ST_T1: begin
          case (op_class)
            CLS_MV: begin
              sel        = operand_sel;
              r_in       = rx_onehot;
              done       = 1'b1;
              state_next = ST_T0;
            end
            CLS_MVT: begin
              sel        = SEL_W'(SEL_IMM);
              r_in       = rx_onehot;
              done       = 1'b1;
              state_next = ST_T0;
            end
            CLS_ALU: begin
              sel        = SEL_W'(rx);
              a_in       = 1'b1;
              state_next = ST_T2;
            end
            default: begin
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
              state_next = ST_HALT;
`else
              done       = 1'b1;
              state_next = ST_T0;
`endif
            end
          endcase
        end
        ST_T2: begin
          sel        = operand_sel;
          g_in       = 1'b1;
          alu_op     = dec_alu_op;
          state_next = ST_T3;
        end
        ST_T3: begin
          sel        = SEL_W'(SEL_G);
          r_in       = rx_onehot;
          done       = 1'b1;
          state_next = ST_T0;
        end
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
        ST_HALT: begin
          illegal    = 1'b1;
          state_next = ST_HALT;
        end
`endif
        default: state_next = ST_T0;
      endcase
    end
  end

endmodule
